// File: rtl/seq_lock_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_lock_ctrl_if
//  Brief    : Control/status bundle between a serial bit source and the
//             combination-lock controller. The master drives pattern, arm,
//             relock and serial bits. The slave returns lock status.
//  Revision : 1.0 - initial release
// ============================================================================
interface seq_lock_ctrl_if #(
  parameter int PAT_W = 4
);
  logic             load_pattern;
  logic [PAT_W-1:0] pattern_in;
  logic             start;
  logic             relock;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             unlocked;
  logic             locked_out;
  logic             attempt_fail;
  logic [3:0]       tries;

  // Source side: drives commands and serial data, observes status.
  modport master (
    output load_pattern, pattern_in, start, relock, x, x_valid,
    input  busy, unlocked, locked_out, attempt_fail, tries
  );

  // Controller side.
  modport slave (
    input  load_pattern, pattern_in, start, relock, x, x_valid,
    output busy, unlocked, locked_out, attempt_fail, tries
  );
endinterface
`default_nettype wire

// File: rtl/seq_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seq_lock_ctrl
//  Brief    : Serial-bit combination lock. Holds a PAT_W-bit pattern and
//             collects PAT_W qualified bits per attempt once armed. It counts
//             failed attempts, which are mismatches or inactivity timeouts,
//             and enters a timed lockout after MAX_TRIES failures.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_lock_ctrl #(
  parameter int PAT_W          = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  wire               clock,
  input  wire               reset,   // synchronous, active low
  seq_lock_ctrl_if.slave    bus
);

  localparam int BIT_W  = $clog2(PAT_W + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);
  localparam int LOCK_W = $clog2(LOCKOUT_CYCLES);

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(PAT_W - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]        TRIES_MAX = 4'(MAX_TRIES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_UNLOCK  = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  state_t             state_q;
  logic [PAT_W-1:0]   pattern_q;
  logic [PAT_W-1:0]   shift_q;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic [IDLE_W-1:0]  idle_cnt_q;
  logic [LOCK_W-1:0]  lock_cnt_q;
  logic [3:0]         tries_q;
  logic               attempt_fail_q;

  // The last bit is compared in the same edge it is shifted in. The shift
  // value seen here is therefore the one that will be registered.
  logic [PAT_W-1:0]   shift_d;
  logic [3:0]         tries_d;
  logic               fail_locks_d;

  // Next shift value and post-failure try count, shared by mismatch and timeout.
  always_comb begin
    shift_d      = {shift_q[PAT_W-2:0], bus.x};
    tries_d      = tries_q + 4'd1;
    fail_locks_d = (tries_d == TRIES_MAX);
  end

  // Lock sequencing: state, pattern, attempt collection and failure tracking.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      pattern_q      <= '1;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      idle_cnt_q     <= '0;
      lock_cnt_q     <= '0;
      tries_q        <= '0;
      attempt_fail_q <= 1'b0;
    end else begin
      attempt_fail_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.load_pattern) pattern_q <= bus.pattern_in;
          if (bus.start) begin
            state_q    <= S_ARMED;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            idle_cnt_q <= '0;
            tries_q    <= '0;
          end
        end

        S_ARMED: begin
          if (bus.relock) begin
            // Abandon the attempt. The pending bit is discarded and no failure is recorded.
            state_q    <= S_IDLE;
            tries_q    <= '0;
            bit_cnt_q  <= '0;
            idle_cnt_q <= '0;
          end else if (bus.x_valid) begin
            shift_q    <= shift_d;
            idle_cnt_q <= '0;
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_q <= '0;
              if (shift_d == pattern_q) begin
                state_q <= S_UNLOCK;
              end else begin
                attempt_fail_q <= 1'b1;
                tries_q        <= tries_d;
                if (fail_locks_d) begin
                  state_q    <= S_LOCKOUT;
                  lock_cnt_q <= '0;
                end
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
          end else if (bit_cnt_q != '0) begin
            // Inactivity only counts once an attempt has begun.
            if (idle_cnt_q == IDLE_LAST) begin
              idle_cnt_q     <= '0;
              bit_cnt_q      <= '0;
              attempt_fail_q <= 1'b1;
              tries_q        <= tries_d;
              if (fail_locks_d) begin
                state_q    <= S_LOCKOUT;
                lock_cnt_q <= '0;
              end
            end else begin
              idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
            end
          end
        end

        S_UNLOCK: begin
          if (bus.load_pattern) pattern_q <= bus.pattern_in;
          if (bus.relock) begin
            state_q <= S_IDLE;
            tries_q <= '0;
          end
        end

        S_LOCKOUT: begin
          // Inputs are deaf here. The state holds for exactly LOCKOUT_CYCLES cycles.
          if (lock_cnt_q == LOCK_LAST) begin
            state_q    <= S_IDLE;
            lock_cnt_q <= '0;
            tries_q    <= '0;
          end else begin
            lock_cnt_q <= lock_cnt_q + LOCK_W'(1);
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Status flags are pure decodes of registered state.
  assign bus.busy         = (state_q == S_ARMED);
  assign bus.unlocked     = (state_q == S_UNLOCK);
  assign bus.locked_out   = (state_q == S_LOCKOUT);
  assign bus.attempt_fail = attempt_fail_q;
  assign bus.tries        = tries_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_lock_ctrl
//  Brief    : Directed self-checking bench for seq_lock_ctrl. Status is
//             compared as {busy, unlocked, locked_out, attempt_fail, tries[3:0]}.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_lock_ctrl;

  logic clock;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  seq_lock_ctrl_if #(.PAT_W(4)) bus ();

  seq_lock_ctrl #(
    .PAT_W          (4),
    .MAX_TRIES      (3),
    .LOCKOUT_CYCLES (16),
    .TIMEOUT_CYCLES (32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge, then settle so outputs reflect that edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {bus.busy, bus.unlocked, bus.locked_out, bus.attempt_fail, bus.tries};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.x       = b;
    bus.x_valid = 1'b1;
    tick();
    bus.x_valid = 1'b0;
  endtask

  task automatic send3(input logic [2:0] b);
    for (int i = 2; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_relock();
    bus.relock = 1'b1;
    tick();
    bus.relock = 1'b0;
  endtask

  initial begin
    reset            = 1'b0;
    bus.load_pattern = 1'b1;
    bus.pattern_in   = 4'b0000;
    bus.start        = 1'b1;
    bus.relock       = 1'b0;
    bus.x            = 1'b1;
    bus.x_valid      = 1'b1;

    // Reset must override all inputs.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold", 8'h00);
    end
    reset            = 1'b1;
    bus.load_pattern = 1'b0;
    bus.start        = 1'b0;
    bus.x_valid      = 1'b0;
    tick();
    chk("idle_after_reset", 8'h00);

    // The reset pattern is 1111.
    pulse_start();
    chk("arm_default", 8'h80);
    send3(3'b111);
    chk("default_3bits_busy", 8'h80);
    send_bit(1'b1);
    chk("default_unlock", 8'h40);
    pulse_relock();
    chk("relock_from_unlock", 8'h00);

    // Load the pattern and start in the same cycle. Enter 1011.
    bus.load_pattern = 1'b1;
    bus.pattern_in   = 4'b1011;
    bus.start        = 1'b1;
    tick();
    bus.load_pattern = 1'b0;
    bus.start        = 1'b0;
    chk("load_and_start", 8'h80);
    send_bit(1'b1); chk("bit1_busy", 8'h80);
    send_bit(1'b0); chk("bit2_busy", 8'h80);
    send_bit(1'b1); chk("bit3_busy", 8'h80);
    send_bit(1'b1); chk("bit4_unlock", 8'h40);
    tick();         chk("unlock_hold", 8'h40);
    pulse_relock(); chk("relock_idle", 8'h00);

    // Two mismatches, then the correct code.
    pulse_start();
    send3(3'b111); send_bit(1'b1);
    chk("mismatch1", 8'h91);
    tick();
    chk("mismatch1_pulse_end", 8'h81);
    send3(3'b100); send_bit(1'b0);
    chk("mismatch2", 8'h92);
    send3(3'b101); send_bit(1'b1);
    chk("unlock_after_fails", 8'h42);
    pulse_relock();
    chk("relock_clears_tries", 8'h00);

    // Three failures lead to lockout. Inputs are ignored during lockout.
    pulse_start();
    send3(3'b000); send_bit(1'b0); chk("lo_fail1", 8'h91);
    send3(3'b000); send_bit(1'b0); chk("lo_fail2", 8'h92);
    send3(3'b000); send_bit(1'b0); chk("lo_enter", 8'h33);
    bus.start   = 1'b1;
    bus.relock  = 1'b1;
    bus.x_valid = 1'b1;
    bus.x       = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("lo_hold", 8'h23);
    end
    tick();
    chk("lo_exit", 8'h00);
    bus.start   = 1'b0;
    bus.relock  = 1'b0;
    bus.x_valid = 1'b0;
    tick();
    chk("lo_idle_after", 8'h00);

    // Timeout boundary: 31 idle cycles is still fine.
    pulse_start();
    send_bit(1'b1);
    for (int i = 0; i < 31; i++) tick();
    chk("idle31_no_fail", 8'h80);
    pulse_relock();
    pulse_start();
    send_bit(1'b1);
    for (int i = 0; i < 31; i++) tick();
    chk("idle31_again", 8'h80);
    tick();
    chk("idle32_timeout", 8'h91);
    tick();
    chk("timeout_pulse_end", 8'h81);
    send3(3'b101); send_bit(1'b1);
    chk("unlock_after_timeout", 8'h41);
    pulse_relock();

    // Relock on the same edge as the correct 4th bit wins.
    pulse_start();
    send3(3'b101);
    bus.x       = 1'b1;
    bus.x_valid = 1'b1;
    bus.relock  = 1'b1;
    tick();
    bus.x_valid = 1'b0;
    bus.relock  = 1'b0;
    chk("relock_beats_bit", 8'h00);
    tick();
    chk("relock_no_unlock", 8'h00);

    // A reset mid-attempt restores the pattern to 1111.
    bus.load_pattern = 1'b1;
    bus.pattern_in   = 4'b0110;
    tick();
    bus.load_pattern = 1'b0;
    pulse_start();
    send_bit(1'b0); send_bit(1'b1);
    reset = 1'b0;
    tick();
    chk("mid_reset", 8'h00);
    reset = 1'b1;
    pulse_start();
    send3(3'b111); send_bit(1'b1);
    chk("pattern_restored", 8'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
